// File: rtl/mdsa_pkg.sv
// Shared types and helpers for the shear sorter: FSM state encoding,
// a constant log2 and the packed element offset.
package mdsa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRow,
        StCol,
        StHold
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bit offset of element (r,c) in a row-major packed N x N matrix.
    function automatic int idx(input int r, input int c, input int n, input int dw);
        return (r * n + c) * dw;
    endfunction

endpackage

// File: rtl/mdsa_shear_sorter_if.sv
// Matrix in/out bus for the shear sorter: valid/ready on both sides,
// order select sampled with the input matrix.
interface mdsa_shear_sorter_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              order;
    logic [N*N*DW-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [N*N*DW-1:0] data_out;

    modport master (
        output in_valid, order, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, order, data_in, out_ready,
        output in_ready, out_valid, data_out
    );

endinterface

// File: rtl/mdsa_cmp_swap.sv
// Compare-exchange cell: lo goes to the lower index (left/top), hi to the higher.
// Elements are swapped only when strictly out of order for the requested direction.
module mdsa_cmp_swap #(
    parameter int unsigned DW     = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          desc,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);
    logic a_gt_b;
    logic b_gt_a;
    logic swap;

    always_comb begin
        if (SIGNED) begin
            a_gt_b = $signed(a) > $signed(b);
            b_gt_a = $signed(b) > $signed(a);
        end else begin
            a_gt_b = a > b;
            b_gt_a = b > a;
        end
        swap = desc ? b_gt_a : a_gt_b;
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/mdsa_shear_sorter.sv
// Shear sorter: sorts an N x N matrix into snake order with alternating row and
// column odd-even transposition phases, one step per enabled cycle.
module mdsa_shear_sorter
    import mdsa_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DW     = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    mdsa_shear_sorter_if.slave bus,
    output logic               busy
);
    localparam int LOG2N = clog2(int'(N));
    localparam int P     = 2 * LOG2N + 1;
    localparam int SW    = LOG2N;
    localparam int PW    = clog2(P + 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            order_q, order_d;
    logic            load;
    logic [DW-1:0]   mat_q [N][N];
    logic [DW-1:0]   mat_d [N][N];
    logic [DW-1:0]   row_lo [N][N-1];
    logic [DW-1:0]   row_hi [N][N-1];
    logic [DW-1:0]   col_lo [N-1][N];
    logic [DW-1:0]   col_hi [N-1][N];
    logic [N*N*DW-1:0] data_flat;

    // Row cells alternate direction per row to build the snake; columns do not.
    for (genvar r = 0; r < N; r++) begin : g_line
        for (genvar p = 0; p < N - 1; p++) begin : g_pair
            mdsa_cmp_swap #(.DW(DW), .SIGNED(SIGNED)) u_row (
                .a    (mat_q[r][p]),
                .b    (mat_q[r][p+1]),
                .desc (order_q ^ ((r % 2) == 1)),
                .lo   (row_lo[r][p]),
                .hi   (row_hi[r][p])
            );
            mdsa_cmp_swap #(.DW(DW), .SIGNED(SIGNED)) u_col (
                .a    (mat_q[p][r]),
                .b    (mat_q[p+1][r]),
                .desc (order_q),
                .lo   (col_lo[p][r]),
                .hi   (col_hi[p][r])
            );
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        order_d = order_q;
        load    = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        order_d = bus.order;
                        step_d  = '0;
                        phase_d = '0;
                        state_d = StRow;
                    end
                end
                StRow, StCol: begin
                    if (step_q == SW'(N - 1)) begin
                        step_d = '0;
                        if (phase_q == PW'(P - 1)) begin
                            state_d = StHold;
                        end else begin
                            phase_d = phase_q + 1'b1;
                            state_d = (state_q == StRow) ? StCol : StRow;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                StHold: begin
                    if (bus.out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Active pairs start at the step parity; they never overlap within a step.
    always_comb begin
        mat_d = mat_q;
        if (load) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mat_d[r][c] = bus.data_in[idx(r, c, N, DW) +: DW];
        end else if (en && state_q == StRow) begin
            for (int r = 0; r < N; r++)
                for (int p = 0; p < N - 1; p++)
                    if (p[0] == step_q[0]) begin
                        mat_d[r][p]   = row_lo[r][p];
                        mat_d[r][p+1] = row_hi[r][p];
                    end
        end else if (en && state_q == StCol) begin
            for (int c = 0; c < N; c++)
                for (int p = 0; p < N - 1; p++)
                    if (p[0] == step_q[0]) begin
                        mat_d[p][c]   = col_lo[p][c];
                        mat_d[p+1][c] = col_hi[p][c];
                    end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            phase_q <= '0;
            order_q <= 1'b0;
            mat_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            order_q <= order_d;
            mat_q   <= mat_d;
        end
    end

    always_comb begin
        data_flat = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                data_flat[idx(r, c, N, DW) +: DW] = mat_q[r][c];
    end

    assign bus.data_out  = data_flat;
    assign bus.in_ready  = en && (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign busy          = (state_q == StRow) || (state_q == StCol);

endmodule

// File: doc/mdsa_shear_sorter.md
Name: mdsa_shear_sorter

Overview:
Parametrised next-generation multidimensional sorter. It sorts an N x N matrix of DW-bit elements into snake (boustrophedon) order using shear sort. Each row/column phase is an odd-even transposition sort of N steps. Control FSM and datapath are integrated, with valid/ready handshakes on both sides. It replaces the fixed 8x8x32 FSM+sorter pair and adds sort-order selection, signed compare and output back-pressure.

Parameters:
N, 8, matrix dimension; power of two, >=2
DW, 32, element width in bits
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
en  input  1  clock enable; low freezes all state
in_valid  input  1  input matrix valid
in_ready  output  1  block can accept a matrix
order  input  1  0 = ascending snake, 1 = descending snake; sampled on accept
data_in  input  N*N*DW  element (r,c) at bits [(r*N+c)*DW +: DW]
out_valid  output  1  sorted matrix valid
out_ready  input  1  consumer accepts the result
data_out  output  N*N*DW  sorted matrix, same packing as data_in
busy  output  1  high in ROW/COL states

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, matrix regs=0, counters=0, out_valid=0, busy=0, data_out=0. in_ready=1 once rst is high and en=1. A reset mid-sort discards the sort, with no partial output.
- in_ready = en && state==IDLE. Accept = in_valid && in_ready: load matrix, latch order, set step=0, set phase=0, go to ROW.
- Phase sequence is ROW, COL repeated LOG2N times, then a final ROW. That gives P = 2*LOG2N+1 phases of N steps each. L = P*N cycles (N=8 gives 56; N=4 gives 20).
- Step parity: even steps compare pairs (0,1),(2,3)…; odd steps compare pairs (1,2),(3,4)…. All rows (ROW) or all columns (COL) are updated in parallel, one step per enabled cycle.
- Direction, order=0: in ROW, even rows put the smaller element left and odd rows put it right. In COL, the smaller element goes to the top.
- Direction, order=1: every direction is inverted.
- Swap only on strict out-of-order; equal elements are not moved. Compare is signed when SIGNED=1.
- The accepting edge is k. Steps occur at enabled edges k+1..k+L. At edge k+L the state goes to HOLD and out_valid rises.
- HOLD: out_valid=1 and data_out is stable until en && out_ready. On that edge, out_valid=0 and the state goes to IDLE. in_ready is low throughout HOLD, so the next accept is no earlier than the following cycle.
- data_out is driven from the matrix register at all times. It is only meaningful while out_valid=1.
- en=0: no state, counter or matrix change, and no handshake completes. Latency extends by the number of stalled cycles.
- in_valid outside IDLE is ignored. Changes to order after accept have no effect.

Decomposition:
- Package mdsa_pkg holds:
  - the state enum (IDLE, ROW, COL, HOLD);
  - a clog2 function;
  - the element index helper idx(r,c) = (r*N+c)*DW.
- Sub-module mdsa_cmp_swap (DW, SIGNED) takes inputs a, b, desc and returns lo/hi outputs. It is instantiated once per row-pair and once per column-pair position, and the result is muxed by phase type.

Test Plan:
1. Reset: hold rst low for 3 cycles, then release -> out_valid=0, busy=0, data_out=0, in_ready=1. Assert rst during ROW -> all outputs cleared immediately.
2. N=4, DW=8, order=0, data_in row-major 15..0 -> out_valid exactly 20 cycles after the accepting edge. Expected rows: [0,1,2,3], [7,6,5,4], [8,9,10,11], [15,14,13,12].
3. Same input, order=1 -> expected rows: [15,14,13,12], [8,9,10,11], [7,6,5,4], [0,1,2,3].
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid while in_valid=1 -> data_out stable, in_ready=0, no new accept. Raise out_ready -> out_valid drops, in_ready=1 the next cycle.
5. SIGNED=1, DW=8, N=2, input {0x7F, 0x80, 0x00, 0xFF}, order=0 -> result [0x80, 0xFF], [0x7F, 0x00]. With SIGNED=0 the result is [0x00, 0x7F], [0xFF, 0x80].
6. Default N=8, DW=32: 200 random matrices with random order, random en drop-outs and out_ready stalls. Each result must match a snake-sort reference model, and latency must equal 56 plus the number of en-low cycles.
